// File: rtl/buf_arb_32bit_pkg.sv
// buf_arb_pkg: shared types and helpers for the buf_arb_32bit arbiter.
//   state_e  - burst FSM state (IDLE / LOCKED)
//   pick_t   - result of a round-robin search (found flag + index)
//   rr_pick  - rotate-priority search from a pointer, wrapping modulo n
package buf_arb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_REQ    = 8;   // upper bound on NUM_REQ supported by rr_pick
  localparam int MAX_ID_W   = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } pick_t;

  // First set bit of valid at or above ptr, wrapping at n.
  // ptr < n is assumed, so one subtraction folds the index back into range.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                    input logic [MAX_ID_W-1:0] ptr,
                                    input int unsigned         n);
    pick_t       r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = {29'd0, ptr} + k;
      if (j >= n) j = j - n;
      if (k < n && !r.found && valid[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/buf_arb_32bit_if.sv
// buf_arb_32bit_if: requester-side and downstream-side handshake bundle.
//   req_valid/req_last/req_data -> arbiter, req_ready <- arbiter
//   out_valid/out_data/out_id/out_last <- arbiter, out_ready -> arbiter
//   master: traffic source/sink side; slave: the arbiter.
interface buf_arb_32bit_if
  import buf_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_last;
  logic                      out_ready;

  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_last
  );

  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, out_last
  );
endinterface

// File: rtl/buf_arb_32bit_rr_picker.sv
// rr_picker: combinational rotate-priority encoder.
//   valid [NUM_REQ] - candidate requesters
//   ptr   [ID_W]    - highest-priority position this round
//   idx   [ID_W]    - winning requester (meaningful when found)
//   found           - at least one valid bit set
module rr_picker
  import buf_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    idx,
  output logic               found
);
  pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(valid), MAX_ID_W'(ptr), NUM_REQ);
    idx   = pick.idx[ID_W-1:0];
    found = pick.found;
  end

  // Upper index bits are always zero for smaller NUM_REQ.
  if (ID_W < MAX_ID_W) begin : g_unused_hi
    logic unused_idx_hi;
    assign unused_idx_hi = ^pick.idx[MAX_ID_W-1:ID_W];
  end
endmodule

// File: rtl/buf_arb_32bit.sv
// buf_arb_32bit: round-robin burst arbiter sharing one registered output
// word among NUM_REQ requesters.
//   clk, reset - rising-edge clock, synchronous active-high reset
//   bus        - slave side of buf_arb_32bit_if (requests in, tagged word out)
//   busy       - registered, high while a multi-beat burst holds the stage
module buf_arb_32bit
  import buf_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            reset,
  buf_arb_32bit_if.slave  bus,
  output logic            busy
);
  state_e                          state_q, state_d;
  logic [ID_W-1:0]                 owner_q, owner_d;
  logic [ID_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                            out_valid_q, out_valid_d;
  logic [DATA_W-1:0]               out_data_q, out_data_d;
  logic [ID_W-1:0]                 out_id_q, out_id_d;
  logic                            out_last_q, out_last_d;
  logic                            busy_q, busy_d;

  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data_a;
  logic [NUM_REQ-1:0]              req_ready;
  logic [ID_W-1:0]                 pick_idx, grant_idx, nxt_ptr;
  logic                            pick_found, grant_any, stage_free;
  logic                            accept, acc_last;

  assign req_data_a = bus.req_data;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Grant / ready generation. The locked owner keeps the grant even while
  // its valid is low, so nobody else can slip into the middle of a burst.
  always_comb begin
    stage_free = !out_valid_q || bus.out_ready;
    if (state_q == LOCKED) begin
      grant_idx = owner_q;
      grant_any = 1'b1;
    end else begin
      grant_idx = pick_idx;
      grant_any = pick_found;
    end
    req_ready = '0;
    if (!reset && stage_free && grant_any) req_ready[grant_idx] = 1'b1;
    accept   = |(bus.req_valid & req_ready);
    acc_last = bus.req_last[grant_idx];
    nxt_ptr  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  // Next-state: pointer only moves at a burst end.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (acc_last) begin
            rr_ptr_d = nxt_ptr;
          end else begin
            state_d = LOCKED;
            owner_d = grant_idx;
          end
        end
        LOCKED: begin
          if (acc_last) begin
            state_d  = IDLE;
            rr_ptr_d = nxt_ptr;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output stage: a new beat wins over a drain in the same cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data_a[grant_idx];
      out_id_d    = grant_idx;
      out_last_d  = acc_last;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    busy_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_buf_arb_32bit.sv
// Randomised bench for buf_arb_32bit: a transaction-level arbitration model
// predicts ready and pushes expected words; a separate monitor pops and
// compares them when the output word is shown / consumed.
module tb_buf_arb_32bit;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  buf_arb_32bit_if #(.NUM_REQ(N), .DATA_W(DW)) bus();

  buf_arb_32bit #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] d;
    bit          l;
  } exp_t;

  exp_t sbq[$];

  // source state per requester
  bit          pres[N];
  logic [31:0] cdat[N];
  bit          clst[N];
  int          rem[N];
  int          seqn[N];
  int          wait_b[N];

  // knobs
  int gen_pct, len_max, ord_pct;

  // model state
  bit m_locked, m_ov, m_busy;
  int m_owner, m_ptr;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && $urandom_range(99) < gen_pct) begin
        if (rem[i] == 0) rem[i] = $urandom_range(len_max, 1);
        pres[i] = 1'b1;
        cdat[i] = {4'(i), 12'(seqn[i]), 16'($urandom)};
        seqn[i]++;
        clst[i] = (rem[i] == 1);
        rem[i]--;
      end
      bus.req_valid[i]          = pres[i];
      bus.req_last[i]           = clst[i];
      bus.req_data[i*DW +: DW]  = cdat[i];
    end
    bus.out_ready = ($urandom_range(99) < ord_pct);
  endtask

  task automatic model_step();
    bit          sf;
    int          g;
    logic [N-1:0] er;
    if (reset) begin
      chk("ready_in_reset", 64'(bus.req_ready), 64'(0));
      m_locked = 0; m_ov = 0; m_busy = 0; m_owner = 0; m_ptr = 0;
      sbq.delete();
      for (int i = 0; i < N; i++) wait_b[i] = 0;
      return;
    end
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("busy", 64'(busy), 64'(m_busy));
    sf = !m_ov || bus.out_ready;
    g  = -1;
    if (m_locked) g = m_owner;
    else
      for (int k = 0; k < N; k++)
        if (g < 0 && pres[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    er = '0;
    if (sf && g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'(1));
    if (sf && g >= 0 && pres[g]) begin
      if (!m_locked) begin
        chk("rr_fairness", 64'(wait_b[g] < N), 64'(1));
        wait_b[g] = 0;
      end
      sbq.push_back('{id: g, d: cdat[g], l: clst[g]});
      pres[g] = 1'b0;
      m_ov    = 1'b1;
      if (clst[g]) begin
        m_locked = 0;
        m_ptr    = (g + 1) % N;
        for (int i = 0; i < N; i++) if (i != g && pres[i]) wait_b[i]++;
      end else begin
        m_locked = 1;
        m_owner  = g;
      end
    end else if (bus.out_ready) begin
      m_ov = 1'b0;
    end
    m_busy = m_locked;
  endtask

  task automatic cycle(input bit rst);
    @(negedge clk);
    reset = rst;
    drive();
    #1;
    model_step();
  endtask

  // monitor: compare the shown word against the oldest expected entry
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.out_valid) begin
        chk("sb_nonempty", 64'(sbq.size() > 0), 64'(1));
        if (sbq.size() > 0) begin
          chk("out_id", 64'(bus.out_id), 64'(sbq[0].id));
          chk("out_data", 64'(bus.out_data), 64'(sbq[0].d));
          chk("out_last", 64'(bus.out_last), 64'(sbq[0].l));
          if (bus.out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pres[i] = 0; cdat[i] = '0; clst[i] = 0; rem[i] = 0; seqn[i] = 0; wait_b[i] = 0;
    end
    m_locked = 0; m_ov = 0; m_busy = 0; m_owner = 0; m_ptr = 0;
    gen_pct = 0; len_max = 1; ord_pct = 100;

    repeat (3) cycle(1'b1);
    // reset values of the output stage
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data",  64'(bus.out_data),  64'(0));
    chk("rst_out_id",    64'(bus.out_id),    64'(0));
    chk("rst_out_last",  64'(bus.out_last),  64'(0));
    chk("rst_busy",      64'(busy),          64'(0));

    // all requesters single-beat, full throughput: grants rotate 0,1,2,3,0...
    gen_pct = 100; len_max = 1; ord_pct = 100;
    repeat (12) cycle(1'b0);

    // multi-beat bursts under a 6-cycle stall, then release
    len_max = 4; ord_pct = 0;
    repeat (6) cycle(1'b0);
    ord_pct = 100;
    repeat (10) cycle(1'b0);

    // random stress with a couple of mid-traffic resets
    gen_pct = 60; len_max = 4; ord_pct = 70;
    for (int c = 0; c < 10000; c++) cycle(c == 3000 || c == 6500);

    // drain
    gen_pct = 0; ord_pct = 100;
    repeat (40) cycle(1'b0);
    chk("sb_drained", 64'(sbq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
